// File: rtl/fsm_run_pkg.sv
// Shared definitions for the run controller and its step counter.
package fsm_run_pkg;

    localparam int DEF_STATE_W = 3;
    localparam int DEF_LEN_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } ctrl_e;

endpackage

// File: rtl/fsm_run_ctrl_counter.sv
// Mod-2^STATE_W step counter; cout flags the step that wraps back to zero.
module step_counter
    import fsm_run_pkg::*;
#(
    parameter int STATE_W = DEF_STATE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               en,
    output logic [STATE_W-1:0] state,
    output logic               cout
);

    localparam logic [STATE_W-1:0] STEP_ONE = 1;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    // clr wins over en so a fresh job or an abort always lands on zero
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = '0;
        end else if (en) begin
            state_d = state_q + STEP_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
    assign cout  = en & (state_q == '1);

endmodule

// File: rtl/fsm_run_ctrl.sv
// Run controller: sequences len full counter wraps per job with pause and abort.
module fsm_run_ctrl
    import fsm_run_pkg::*;
#(
    parameter int STATE_W = DEF_STATE_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic               pause,
    input  logic               abort,
    output logic [STATE_W-1:0] state,
    output logic               cout,
    output logic [LEN_W-1:0]   wraps,
    output logic               busy,
    output logic               done
);

    localparam logic [LEN_W-1:0] WRAP_ONE = 1;

    ctrl_e            ctrl_q, ctrl_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] wraps_q, wraps_d;
    logic [LEN_W-1:0] wrapsInc;
    logic             cntClr;
    logic             cntEn;
    logic             atTop;

    step_counter #(
        .STATE_W (STATE_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cntClr),
        .en    (cntEn),
        .state (state),
        .cout  (cout)
    );

    assign atTop    = (state == '1);
    assign wrapsInc = wraps_q + WRAP_ONE;

    // Leaving PAUSED already counts as a step, so a pause costs exactly
    // as many cycles as pause was held high.
    always_comb begin
        ctrl_d  = ctrl_q;
        len_d   = len_q;
        wraps_d = wraps_q;
        cntClr  = 1'b0;
        cntEn   = 1'b0;
        case (ctrl_q)
            IDLE: begin
                if (start) begin
                    wraps_d = '0;
                    if (len != '0) begin
                        len_d  = len;
                        cntClr = 1'b1;
                        ctrl_d = RUN;
                    end else begin
                        ctrl_d = DONE;
                    end
                end
            end
            RUN, PAUSED: begin
                if (abort) begin
                    cntClr = 1'b1;
                    ctrl_d = IDLE;
                end else if (pause) begin
                    ctrl_d = PAUSED;
                end else begin
                    cntEn  = 1'b1;
                    ctrl_d = RUN;
                    if (atTop) begin
                        wraps_d = wrapsInc;
                        if (wrapsInc == len_q) begin
                            ctrl_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                ctrl_d = IDLE;
            end
            default: begin
                ctrl_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= IDLE;
            len_q   <= '0;
            wraps_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            len_q   <= len_d;
            wraps_q <= wraps_d;
        end
    end

    assign wraps = wraps_q;
    assign busy  = (ctrl_q == RUN) || (ctrl_q == PAUSED);
    assign done  = (ctrl_q == DONE);

endmodule

// File: tb/tb_fsm_run_ctrl.sv
// Directed bench for fsm_run_ctrl with STATE_W=3, LEN_W=8.
module tb_fsm_run_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] len;
    logic       pause;
    logic       abort;
    logic [2:0] state;
    logic       cout;
    logic [7:0] wraps;
    logic       busy;
    logic       done;

    int totalChecks = 0;
    int badChecks   = 0;

    fsm_run_ctrl #(
        .STATE_W (3),
        .LEN_W   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .len   (len),
        .pause (pause),
        .abort (abort),
        .state (state),
        .cout  (cout),
        .wraps (wraps),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic rst, input logic st, input int ln,
                                 input logic ps, input logic ab);
        reset = rst;
        start = st;
        len   = ln[7:0];
        pause = ps;
        abort = ab;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", tag, observed, expected);
        end
    endtask

    // One rising edge, then land on the falling edge where outputs are stable
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic waitDone(input int maxCycles, output int n);
        n = maxCycles + 1;
        for (int i = 1; i <= maxCycles; i++) begin
            tick();
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int coutSeen;
        int busySeen;
        int doneSeen;
        int n;

        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst_state", state, 0);
            checkOutput("rst_busy", busy, 0);
            checkOutput("rst_done", done, 0);
            checkOutput("rst_cout", cout, 0);
            tick();
        end
        checkOutput("rst_wraps", wraps, 0);

        // Plain two-wrap job
        applyStimulus(1'b0, 1'b1, 2, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
        coutSeen = 0;
        busySeen = 0;
        for (int i = 0; i < 16; i++) begin
            checkOutput("run2_state", state, i % 8);
            checkOutput("run2_cout", cout, (i % 8 == 7) ? 1 : 0);
            coutSeen += cout;
            busySeen += busy;
            tick();
        end
        checkOutput("run2_coutcount", coutSeen, 2);
        checkOutput("run2_busycount", busySeen, 16);
        checkOutput("run2_done", done, 1);
        checkOutput("run2_busyend", busy, 0);
        checkOutput("run2_wraps", wraps, 2);
        checkOutput("run2_stateend", state, 0);
        tick();
        checkOutput("run2_donepulse", done, 0);

        // One-wrap job paused for four cycles at state 3
        applyStimulus(1'b0, 1'b1, 1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("pause_pre", state, 3);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);
        for (int j = 0; j < 4; j++) begin
            tick();
            checkOutput("pause_hold", state, 3);
            checkOutput("pause_busy", busy, 1);
        end
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
        tick();
        checkOutput("pause_resume", state, 4);
        waitDone(20, n);
        checkOutput("pause_donelat", n, 4);
        checkOutput("pause_wraps", wraps, 1);
        tick();

        // Abort at state 5 of the first wrap
        applyStimulus(1'b0, 1'b1, 3, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) tick();
        checkOutput("abort_pre", state, 5);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_state", state, 0);
        checkOutput("abort_wraps", wraps, 0);
        checkOutput("abort_done", done, 0);
        doneSeen = 0;
        busySeen = 0;
        for (int j = 0; j < 40; j++) begin
            tick();
            doneSeen += done;
            busySeen += busy;
        end
        checkOutput("abort_nodone", doneSeen, 0);
        checkOutput("abort_idle", busySeen, 0);

        // Reset in the middle of a four-wrap job
        applyStimulus(1'b0, 1'b1, 4, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int j = 0; j < 7; j++) tick();
        checkOutput("midrst_pre", state, 7);
        checkOutput("midrst_cout", cout, 1);
        applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0);
        tick();
        checkOutput("midrst_state", state, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_cout0", cout, 0);
        checkOutput("midrst_wraps", wraps, 0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
        tick();
        checkOutput("midrst_after", busy, 0);
        checkOutput("midrst_nodone", done, 0);

        // A start with a new len while busy must not disturb the job
        applyStimulus(1'b0, 1'b1, 2, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        applyStimulus(1'b0, 1'b1, 1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("busystart_state", state, 4);
        checkOutput("busystart_busy", busy, 1);
        waitDone(40, n);
        checkOutput("busystart_donelat", n, 12);
        checkOutput("busystart_wraps", wraps, 2);
        tick();

        // Zero-length job completes immediately without going busy
        applyStimulus(1'b0, 1'b1, 0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b0);
        checkOutput("len0_done", done, 1);
        checkOutput("len0_busy", busy, 0);
        checkOutput("len0_wraps", wraps, 0);
        tick();
        checkOutput("len0_donepulse", done, 0);
        checkOutput("len0_busyafter", busy, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
